// File: rtl/atmos_light_est.sv
// rtl/atmos_light_est.sv - per-frame atmospheric-light estimator for the dehaze pipeline
//
// Watches the camera stream and, within each frame, keeps the pixel with the
// largest dark channel min(R,G,B). When the frame ends, it publishes the
// atmospheric light A. A can optionally be IIR-smoothed across frames.
//
// Ports:
//   clk             pixel clock
//   rst_n           asynchronous active-low reset
//   pre_frame_vsync high for the duration of a frame
//   pre_frame_href  high during an active line
//   pre_frame_clken pixel qualifier
//   pre_img         {R[23:16], G[15:8], B[7:0]}
//   atmos_light     current A estimate
//   atmos_rgb       RGB of the max-dark-channel pixel of the last good frame
//   atmos_valid     one-cycle pulse per completed frame (good or bad)
//   frame_err       last frame failed the geometry check; held until the next update
module atmos_light_est #(
    parameter int IMG_HDISP    = 640,
    parameter int IMG_VDISP    = 480,
    parameter int A_INIT       = 220,
    parameter int A_MAX        = 240,
    parameter int SMOOTH_SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pre_frame_vsync,
    input  logic        pre_frame_href,
    input  logic        pre_frame_clken,
    input  logic [23:0] pre_img,
    output logic [7:0]  atmos_light,
    output logic [23:0] atmos_rgb,
    output logic        atmos_valid,
    output logic        frame_err
);

    localparam logic [7:0]  A_INIT_L = 8'(A_INIT);
    localparam logic [7:0]  A_MAX_L  = 8'(A_MAX);
    localparam logic [15:0] HDISP_L  = 16'(IMG_HDISP);
    localparam logic [15:0] VDISP_L  = 16'(IMG_VDISP);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_UPDATE} state_t;

    state_t      state, next_state;
    logic        vsync_d1, href_d1;
    logic        vsync_rise, vsync_fall;
    logic        clear_frame, pix_accept, line_end, do_update;

    logic [7:0]  max_dark;
    logic [23:0] cand_rgb;
    logic [15:0] col_cnt, line_cnt;
    logic        line_err, any_pix, have_good;

    function automatic logic [7:0] min3(input logic [23:0] p);
        logic [7:0] m;
        m = (p[23:16] < p[15:8]) ? p[23:16] : p[15:8];
        return (m < p[7:0]) ? m : p[7:0];
    endfunction

    function automatic logic [7:0] max3(input logic [23:0] p);
        logic [7:0] m;
        m = (p[23:16] > p[15:8]) ? p[23:16] : p[15:8];
        return (m > p[7:0]) ? m : p[7:0];
    endfunction

    assign vsync_rise = pre_frame_vsync & ~vsync_d1;
    assign vsync_fall = ~pre_frame_vsync & vsync_d1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic; a fall seen in IDLE is simply ignored
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (vsync_rise) next_state = S_ACTIVE;
            S_ACTIVE: if (vsync_fall) next_state = S_UPDATE;
            S_UPDATE: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // FSM control outputs. A pixel in the rise cycle arrives while still in IDLE,
    // so it is dropped and shows up later as a short line.
    always_comb begin
        clear_frame = 1'b0;
        pix_accept  = 1'b0;
        line_end    = 1'b0;
        do_update   = 1'b0;
        case (state)
            S_IDLE:   clear_frame = vsync_rise;
            S_ACTIVE: begin
                pix_accept = pre_frame_vsync & pre_frame_href & pre_frame_clken;
                line_end   = href_d1 & ~pre_frame_href;
            end
            S_UPDATE: do_update = 1'b1;
            default:  ;
        endcase
    end

    // Frame verdict and candidate A
    logic              frame_bad;
    logic [7:0]        cand_max, a_frame, a_smooth, a_next;
    logic signed [8:0] a_diff, a_step;

    always_comb begin
        frame_bad = line_err | (line_cnt != VDISP_L) | ~any_pix;
        cand_max  = max3(cand_rgb);
        a_frame   = (cand_max > A_MAX_L) ? A_MAX_L : cand_max;
        a_diff    = $signed({1'b0, a_frame}) - $signed({1'b0, atmos_light});
        a_step    = a_diff >>> SMOOTH_SHIFT;
        // The result always lies between A and Af, so 8-bit wraparound is exact
        a_smooth  = atmos_light + a_step[7:0];
        a_next    = (!have_good || SMOOTH_SHIFT == 0) ? a_frame : a_smooth;
    end

    // Datapath. vsync_d1 resets high so a frame already running at release is skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d1    <= 1'b1;
            href_d1     <= 1'b0;
            max_dark    <= 8'd0;
            cand_rgb    <= 24'd0;
            col_cnt     <= 16'd0;
            line_cnt    <= 16'd0;
            line_err    <= 1'b0;
            any_pix     <= 1'b0;
            have_good   <= 1'b0;
            atmos_light <= A_INIT_L;
            atmos_rgb   <= 24'd0;
            atmos_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            vsync_d1    <= pre_frame_vsync;
            href_d1     <= pre_frame_href;
            atmos_valid <= do_update;

            if (clear_frame) begin
                max_dark <= 8'd0;
                cand_rgb <= 24'd0;
                col_cnt  <= 16'd0;
                line_cnt <= 16'd0;
                line_err <= 1'b0;
                any_pix  <= 1'b0;
            end

            if (pix_accept) begin
                any_pix <= 1'b1;
                if (col_cnt != 16'hFFFF) col_cnt <= col_cnt + 16'd1;
                // Strict compare so ties keep the earliest pixel
                if (min3(pre_img) > max_dark) begin
                    max_dark <= min3(pre_img);
                    cand_rgb <= pre_img;
                end
            end

            if (line_end) begin
                if (col_cnt != HDISP_L) line_err <= 1'b1;
                if (line_cnt != 16'hFFFF) line_cnt <= line_cnt + 16'd1;
                col_cnt <= 16'd0;
            end

            if (do_update) begin
                frame_err <= frame_bad;
                if (!frame_bad) begin
                    atmos_rgb   <= cand_rgb;
                    atmos_light <= a_next;
                    have_good   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_atmos_light_est.sv
// tb/tb_atmos_light_est.sv - directed self-checking bench for atmos_light_est
module tb_atmos_light_est;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic        clken = 1'b0;
    logic [23:0] img = 24'd0;

    logic [7:0]  light, light_s;
    logic [23:0] rgb, rgb_s;
    logic        valid, valid_s;
    logic        ferr, ferr_s;

    int checks = 0;
    int errors = 0;

    logic [23:0] pix [0:11];
    int          llen [0:2];
    int          vcnt;
    logic [7:0]  cap_light, cap_light_s;
    logic [23:0] cap_rgb;
    logic        cap_err;

    always #5 clk = ~clk;

    atmos_light_est #(.IMG_HDISP(4), .IMG_VDISP(3), .SMOOTH_SHIFT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .pre_frame_vsync(vsync), .pre_frame_href(href), .pre_frame_clken(clken),
        .pre_img(img),
        .atmos_light(light), .atmos_rgb(rgb), .atmos_valid(valid), .frame_err(ferr)
    );

    atmos_light_est #(.IMG_HDISP(4), .IMG_VDISP(3), .SMOOTH_SHIFT(2)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .pre_frame_vsync(vsync), .pre_frame_href(href), .pre_frame_clken(clken),
        .pre_img(img),
        .atmos_light(light_s), .atmos_rgb(rgb_s), .atmos_valid(valid_s), .frame_err(ferr_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [23:0] p);
        for (int i = 0; i < 12; i++) pix[i] = p;
        for (int l = 0; l < 3; l++) llen[l] = 4;
    endtask

    // Drive one frame from pix/llen, then watch a bounded window for the valid pulse
    task automatic run_frame();
        int idx;
        idx = 0;
        vsync = 1'b1; href = 1'b0; clken = 1'b0;
        tick(); tick();
        for (int l = 0; l < 3; l++) begin
            for (int p = 0; p < llen[l]; p++) begin
                href = 1'b1; clken = 1'b1; img = pix[idx];
                idx++;
                tick();
            end
            href = 1'b0; clken = 1'b0; img = 24'd0;
            tick(); tick();
        end
        vsync = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (valid) begin
                vcnt++;
                cap_light   = light;
                cap_light_s = light_s;
                cap_rgb     = rgb;
                cap_err     = ferr;
            end
        end
    endtask

    initial begin
        tick(); tick();
        check("reset_light", 32'(light), 32'd220);
        check("reset_rgb", 32'(rgb), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_err", 32'(ferr), 32'd0);
        rst_n = 1'b1;
        tick(); tick();

        // Uniform frame (100,150,200)
        fill(24'h6496C8);
        run_frame();
        check("f1_vcnt", 32'(vcnt), 32'd1);
        check("f1_light", 32'(cap_light), 32'd200);
        check("f1_rgb", 32'(cap_rgb), 32'h6496C8);
        check("f1_err", 32'(cap_err), 32'd0);
        check("f1_light_smooth", 32'(cap_light_s), 32'd200);
        check("f1_valid_drop", 32'(valid), 32'd0);

        // Frame with A=120: direct vs smoothed 200+(-80>>>2)=180
        fill(24'h78646E);
        run_frame();
        check("f2_light", 32'(cap_light), 32'd120);
        check("f2_light_smooth", 32'(cap_light_s), 32'd180);
        check("f2_rgb", 32'(cap_rgb), 32'h78646E);

        // Single bright pixel, clamped to A_MAX
        fill(24'h0A0A0A);
        pix[5] = 24'hFAF5F8;
        run_frame();
        check("f3_rgb", 32'(cap_rgb), 32'hFAF5F8);
        check("f3_light", 32'(cap_light), 32'd240);

        // Tie on dark=90 keeps the earlier pixel
        fill(24'h0A0A0A);
        pix[2] = 24'h5A7882;
        pix[7] = 24'h5F5AC8;
        run_frame();
        check("f4_rgb", 32'(cap_rgb), 32'h5A7882);
        check("f4_light", 32'(cap_light), 32'd130);

        // Short second line -> geometry error, outputs held
        fill(24'h808080);
        llen[1] = 3;
        run_frame();
        check("f5_vcnt", 32'(vcnt), 32'd1);
        check("f5_err", 32'(cap_err), 32'd1);
        check("f5_light", 32'(cap_light), 32'd130);
        check("f5_rgb", 32'(cap_rgb), 32'h5A7882);

        // Good frame clears frame_err
        fill(24'h6496C8);
        run_frame();
        check("f6_err", 32'(cap_err), 32'd0);
        check("f6_light", 32'(cap_light), 32'd200);
        check("f6_hold_light", 32'(light), 32'd200);

        // Reset mid-frame
        vsync = 1'b1;
        tick(); tick();
        href = 1'b1; clken = 1'b1; img = 24'hFFFFFF;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("rst_async_light", 32'(light), 32'd220);
        check("rst_async_rgb", 32'(rgb), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        href = 1'b0; clken = 1'b0;
        tick(); tick();
        vsync = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (valid) vcnt++;
        end
        check("rst_partial_vcnt", 32'(vcnt), 32'd0);
        check("rst_partial_light", 32'(light), 32'd220);

        fill(24'h78646E);
        run_frame();
        check("rst_next_vcnt", 32'(vcnt), 32'd1);
        check("rst_next_light", 32'(cap_light), 32'd120);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
